// File: rtl/alu_mc_pkg.sv
// Opcode encodings and FSM state type shared by the multi-cycle ALU and its engine.
package alu_mc_pkg;

    localparam logic [3:0] OP_RLL  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_RRL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_ANDN = 4'b0111;
    localparam logic [3:0] OP_REV  = 4'b1000;
    localparam logic [3:0] OP_SLBI = 4'b1001;
    localparam logic [3:0] OP_LBI  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIV  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative engine: unsigned shift-add multiply, and restoring divide when ALU_MC_DIV_EN is defined.
// The first iteration happens on the go edge, so done pulses WIDTH-1 cycles after go.
module muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             load;
    logic [WIDTH-1:0] cur_lo, cur_hi, cur_b;
    logic [WIDTH-1:0] step_lo, step_hi;
    logic [WIDTH:0]   sum;

`ifdef ALU_MC_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   rem, diff;
`else
    logic             div_unused;
    assign div_unused = is_div;
`endif

    assign load = go && !busy_q;

    // One iteration step; on the load cycle it operates on the fresh operands.
    always_comb begin
        cur_lo  = load ? a : lo_q;
        cur_hi  = load ? '0 : hi_q;
        cur_b   = load ? b : b_q;
        sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], cur_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        rem  = {cur_hi, cur_lo[WIDTH-1]};
        diff = rem - {1'b0, cur_b};
        if (load ? is_div : div_q) begin
            if (rem >= {1'b0, cur_b}) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {cur_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem[WIDTH-1:0];
                step_lo = {cur_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        b_d    = b_q;
`ifdef ALU_MC_DIV_EN
        div_d  = div_q;
`endif
        if (load) begin
            b_d    = b;
`ifdef ALU_MC_DIV_EN
            div_d  = is_div;
`endif
            lo_d   = step_lo;
            hi_d   = step_hi;
            cnt_d  = CNTW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            lo_d = step_lo;
            hi_d = step_hi;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            b_q    <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            b_q    <= b_d;
`ifdef ALU_MC_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with start/ready/valid handshake and registered results.
// Define ALU_MC_DIV_EN to include the DIV op and divider datapath; otherwise opcode 1101 is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             invA,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHi,
    output logic             Ofl,
    output logic             Z,
    output logic             N,
    output logic             Cout,
    output logic             err
);

    localparam int unsigned CNTW = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic             ofl_q, ofl_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0]   in_a;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sh_v;
    logic [CNTW-1:0]    amt;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rev;
    logic [WIDTH-1:0]   r_out, r_hi;
    logic               r_ofl, r_cout, r_err;

    logic               eng_go, eng_is_div, eng_busy, eng_done;
    logic [WIDTH-1:0]   eng_lo, eng_hi;

    assign in_a = invA ? ~A : A;
    assign sum  = {1'b0, in_a} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign rev[g] = in_a[WIDTH-1-g];
    end

    // Log-stage barrel shifter; op[1:0] selects rll/sll/rrl/srl.
    always_comb begin
        sh_v = in_a;
        amt  = B[CNTW-1:0];
        dbl  = '0;
        for (int unsigned i = 0; i < CNTW; i++) begin
            if (amt[0]) begin
                case (op[1:0])
                    2'b00: begin
                        dbl  = {sh_v, sh_v} << (1 << i);
                        sh_v = dbl[2*WIDTH-1:WIDTH];
                    end
                    2'b01: sh_v = sh_v << (1 << i);
                    2'b10: begin
                        dbl  = {sh_v, sh_v} >> (1 << i);
                        sh_v = dbl[WIDTH-1:0];
                    end
                    default: sh_v = sh_v >> (1 << i);
                endcase
            end
            amt = amt >> 1;
        end
    end

    // Results of the ops that complete in the start cycle.
    always_comb begin
        r_out  = '0;
        r_hi   = '0;
        r_ofl  = 1'b0;
        r_cout = 1'b0;
        r_err  = 1'b0;
        case (op)
            OP_RLL, OP_SLL, OP_RRL, OP_SRL: r_out = sh_v;
            OP_ADD: begin
                r_out  = sum[WIDTH-1:0];
                r_cout = sum[WIDTH];
                r_ofl  = (in_a[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_OR:   r_out = in_a | B;
            OP_XOR:  r_out = in_a ^ B;
            OP_ANDN: r_out = in_a & ~B;
            OP_REV:  r_out = rev;
            OP_SLBI: r_out = (in_a << HALF) | {{HALF{1'b0}}, B[HALF-1:0]};
            OP_LBI:  r_out = B;
            OP_MUL:  r_out = '0;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                r_out = '1;
                r_hi  = A;
                r_err = 1'b1;
            end
`endif
            default: r_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        out_d      = out_q;
        out_hi_d   = out_hi_q;
        ofl_d      = ofl_q;
        z_d        = z_q;
        n_d        = n_q;
        cout_d     = cout_q;
        err_d      = err_q;
        eng_go     = 1'b0;
        eng_is_div = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !eng_busy) begin
                    if (op == OP_MUL) begin
                        eng_go  = 1'b1;
                        state_d = MUL;
`ifdef ALU_MC_DIV_EN
                    end else if (op == OP_DIV && B != '0) begin
                        eng_go     = 1'b1;
                        eng_is_div = 1'b1;
                        state_d    = DIV;
`endif
                    end else begin
                        valid_d  = 1'b1;
                        out_d    = r_out;
                        out_hi_d = r_hi;
                        ofl_d    = r_ofl;
                        cout_d   = r_cout;
                        err_d    = r_err;
                    end
                end
            end
            MUL: begin
                if (eng_done) begin
                    valid_d  = 1'b1;
                    out_d    = eng_lo;
                    out_hi_d = eng_hi;
                    ofl_d    = |eng_hi;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
`ifdef ALU_MC_DIV_EN
            DIV: begin
                if (eng_done) begin
                    valid_d  = 1'b1;
                    out_d    = eng_lo;
                    out_hi_d = eng_hi;
                    ofl_d    = 1'b0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (valid_d) begin
            z_d = (out_d == '0);
            n_d = out_d[WIDTH-1];
        end
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            out_q    <= '0;
            out_hi_q <= '0;
            ofl_q    <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            ofl_q    <= ofl_d;
            z_q      <= z_d;
            n_q      <= n_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go     (eng_go),
        .is_div (eng_is_div),
        .a      (A),
        .b      (B),
        .busy   (eng_busy),
        .done   (eng_done),
        .lo     (eng_lo),
        .hi     (eng_hi)
    );

    assign ready = ready_q;
    assign valid = valid_q;
    assign Out   = out_q;
    assign OutHi = out_hi_q;
    assign Ofl   = ofl_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign Cout  = cout_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc at WIDTH=16 against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 16;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = 4'h0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Cin = 1'b0;
    logic          invA = 1'b0;
    logic          ready, valid, Ofl, Z, N, Cout, err;
    logic [W-1:0]  Out, OutHi;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .Cin(Cin), .invA(invA),
        .ready(ready), .valid(valid), .Out(Out), .OutHi(OutHi), .Ofl(Ofl), .Z(Z), .N(N),
        .Cout(Cout), .err(err)
    );

    // Expected {Out, OutHi, Ofl, Z, N, Cout, err} computed from the op definitions.
    function automatic logic [36:0] model(input logic [3:0] mop, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic inva);
        logic [15:0] ina, o, hi;
        logic ofl, cout, er;
        int sh, s, ss;
        longint p;
        ina = inva ? ~a : a;
        o = '0; hi = '0; ofl = 1'b0; cout = 1'b0; er = 1'b0;
        sh = int'(b[3:0]);
        case (mop)
            4'h0: for (int i = 0; i < 16; i++) o[(i + sh) % 16] = ina[i];
            4'h1: for (int i = 0; i < 16; i++) if (i + sh < 16) o[i + sh] = ina[i];
            4'h2: for (int i = 0; i < 16; i++) o[i] = ina[(i + sh) % 16];
            4'h3: for (int i = 0; i < 16; i++) if (i + sh < 16) o[i] = ina[i + sh];
            4'h4: begin
                s = int'(ina) + int'(b) + int'(cin);
                o = 16'(s);
                cout = (s > 65535);
                ss = int'($signed(ina)) + int'($signed(b)) + int'(cin);
                ofl = (ss > 32767) || (ss < -32768);
            end
            4'h5: o = ina | b;
            4'h6: o = ina ^ b;
            4'h7: o = ina & ~b;
            4'h8: for (int i = 0; i < 16; i++) o[15 - i] = ina[i];
            4'h9: o = 16'((int'(ina) * 256) % 65536 + int'(b) % 256);
            4'hB: o = b;
            4'hC: begin
                p = longint'(a) * longint'(b);
                o = 16'(p);
                hi = 16'(p >> 16);
                ofl = (hi != 0);
            end
            4'hD: begin
                if (!DIV_EN) er = 1'b1;
                else if (b == 0) begin o = 16'hFFFF; hi = a; er = 1'b1; end
                else begin o = a / b; hi = a % b; end
            end
            default: er = 1'b1;
        endcase
        return {o, hi, ofl, (o == 16'h0), o[15], cout, er};
    endfunction

    function automatic int exp_latency(input logic [3:0] mop, input logic [15:0] b);
        if (mop == 4'hC) return W + 1;
        if (mop == 4'hD && DIV_EN && b != 0) return W + 1;
        return 1;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic ia);
        @(negedge clk);
        op = o; A = a; B = b; Cin = c; invA = ia; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Bounded wait for valid; cycle numbering continues from cyc_in.
    task automatic wait_valid(input int cyc_in, output int cyc, output int rdy_low);
        cyc = cyc_in;
        rdy_low = 0;
        while (valid !== 1'b1 && cyc < 200) begin
            if (ready === 1'b0) rdy_low++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, valid, Out, OutHi, Ofl, Z, N, Cout, err} !== {1'b1, 1'b0, 37'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b out=%h hi=%h flags=%b%b%b%b%b, want rdy=1 vld=0 all zero",
                     ready, valid, Out, OutHi, Ofl, Z, N, Cout, err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [36:0] exp;
        logic [15:0] a, b;
        logic c, ia;
        issue(4'h4, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        n_checks++;
        if ({valid, Out, Ofl, Z, N, Cout, err} !== {1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf: got vld=%b out=%h ofl=%b z=%b n=%b cout=%b err=%b, want 1 8000 1 0 1 0 0",
                     valid, Out, Ofl, Z, N, Cout, err);
        end
        for (int k = 0; k < 12; k++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); ia = 1'($urandom);
            if (k == 0) begin a = 16'hFFFF; b = 16'h0001; c = 1'b0; ia = 1'b0; end
            exp = model(4'h4, a, b, c, ia);
            issue(4'h4, a, b, c, ia);
            n_checks++;
            if (valid !== 1'b1 || {Out, OutHi, Ofl, Z, N, Cout, err} !== exp) begin
                n_fail++;
                $display("FAIL add_rand: a=%h b=%h cin=%b inv=%b got vld=%b vec=%h want vld=1 vec=%h",
                         a, b, c, ia, valid, {Out, OutHi, Ofl, Z, N, Cout, err}, exp);
            end
        end
    endtask

    task automatic test_single_random();
        logic [36:0] exp;
        logic [15:0] a, b;
        logic [3:0] o;
        logic c, ia;
        for (int k = 0; k < 40; k++) begin
            do o = 4'($urandom_range(0, 15)); while (exp_latency(o, 16'h1) != 1);
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); ia = 1'($urandom);
            exp = model(o, a, b, c, ia);
            issue(o, a, b, c, ia);
            n_checks++;
            if (valid !== 1'b1 || ready !== 1'b1 || {Out, OutHi, Ofl, Z, N, Cout, err} !== exp) begin
                n_fail++;
                $display("FAIL single_op: op=%h a=%h b=%h cin=%b inv=%b got vld=%b rdy=%b vec=%h want vld=1 rdy=1 vec=%h",
                         o, a, b, c, ia, valid, ready, {Out, OutHi, Ofl, Z, N, Cout, err}, exp);
            end
        end
    endtask

    task automatic test_multi(input logic [3:0] o, input int nrand);
        logic [36:0] exp;
        logic [15:0] a, b;
        logic ia;
        int cyc, rl, lat;
        for (int k = 0; k < nrand + 2; k++) begin
            a = 16'($urandom); b = 16'($urandom); ia = 1'($urandom);
            if (o == 4'hC && k == 0) begin a = 16'h00FF; b = 16'h0101; end
            if (o == 4'hC && k == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
            if (o == 4'hD && k == 0) begin a = 16'h0064; b = 16'h0007; end
            if (o == 4'hD && k == 1) begin a = 16'h0064; b = 16'h0000; end
            if (o == 4'hD && k > 1 && k % 3 == 0) b = 16'($urandom_range(1, 300));
            exp = model(o, a, b, 1'($urandom), ia);
            lat = exp_latency(o, b);
            issue(o, a, b, 1'b0, ia);
            wait_valid(1, cyc, rl);
            n_checks++;
            if (cyc != lat || rl != lat - 1) begin
                n_fail++;
                $display("FAIL multi_latency: op=%h a=%h b=%h got valid_cycle=%0d ready_low=%0d want %0d and %0d",
                         o, a, b, cyc, rl, lat, lat - 1);
            end
            n_checks++;
            if (ready !== 1'b1 || {Out, OutHi, Ofl, Z, N, Cout, err} !== exp) begin
                n_fail++;
                $display("FAIL multi_result: op=%h a=%h b=%h got rdy=%b vec=%h want rdy=1 vec=%h",
                         o, a, b, ready, {Out, OutHi, Ofl, Z, N, Cout, err}, exp);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL multi_pulse: op=%h valid after result got %b want 0", o, valid);
            end
        end
    endtask

    task automatic test_handshake_reset();
        logic [36:0] exp;
        int cyc, rl, nvalid;
        exp = model(4'hC, 16'h1234, 16'h0055, 1'b0, 1'b0);
        issue(4'hC, 16'h1234, 16'h0055, 1'b0, 1'b0);
        nvalid = 0;
        for (int c = 1; c < 5; c++) begin
            if (valid === 1'b1) nvalid++;
            @(posedge clk);
            #1;
        end
        op = 4'h4; A = 16'h0001; B = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (valid === 1'b1) nvalid++;
        wait_valid(6, cyc, rl);
        n_checks++;
        if (cyc != W + 1 || nvalid != 0 || {Out, OutHi, Ofl, Z, N, Cout, err} !== exp) begin
            n_fail++;
            $display("FAIL ignored_start: got valid_cycle=%0d early_valids=%0d vec=%h want %0d 0 %h",
                     cyc, nvalid, {Out, OutHi, Ofl, Z, N, Cout, err}, W + 1, exp);
        end
        nvalid = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nvalid++;
        end
        n_checks++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL ignored_start_late: extra valid pulses got %0d want 0", nvalid);
        end

        issue(4'hC, 16'hABCD, 16'h1357, 1'b0, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, valid, Out, OutHi, Ofl, Z, N, Cout, err} !== {1'b1, 1'b0, 37'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got rdy=%b vld=%b out=%h hi=%h flags=%b%b%b%b%b want rdy=1 vld=0 all zero",
                     ready, valid, Out, OutHi, Ofl, Z, N, Cout, err);
        end
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nvalid++;
        end
        n_checks++;
        if (nvalid != 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: got valids=%0d rdy=%b want 0 and 1", nvalid, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [4];
        logic [15:0] as   [4];
        logic [15:0] bs   [4];
        logic [15:0] outs [4];
        logic [36:0] exp;
        ops = '{4'h0, 4'h9, 4'h8, 4'hE};
        as  = '{16'h8001, 16'h0012, 16'h0001, 16'h5555};
        bs  = '{16'h0001, 16'h0034, 16'h0000, 16'hAAAA};
        outs = '{16'h0003, 16'h1234, 16'h8000, 16'h0000};
        @(negedge clk);
        op = ops[0]; A = as[0]; B = bs[0]; Cin = 1'b0; invA = 1'b0; start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            exp = model(ops[k], as[k], bs[k], 1'b0, 1'b0);
            n_checks++;
            if (valid !== 1'b1 || Out !== outs[k] || {Out, OutHi, Ofl, Z, N, Cout, err} !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: op=%h got vld=%b out=%h vec=%h want vld=1 out=%h vec=%h",
                         k, ops[k], valid, Out, {Out, OutHi, Ofl, Z, N, Cout, err}, outs[k], exp);
            end
            if (k < 3) begin
                op = ops[k + 1]; A = as[k + 1]; B = bs[k + 1];
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (err !== 1'b1 || Z !== 1'b1 || N !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_flags: got err=%b z=%b n=%b want 1 1 0", err, Z, N);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_single_random();
        test_multi(4'hC, 8);
        test_multi(4'hD, 8);
        test_handshake_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the 16-bit combinational datapath ALU.
- Keeps the logic, shift, add, bit-reverse, SLBI and LBI op set, generalised to WIDTH bits.
- Adds unsigned iterative multiply and divide.
- Results are registered and returned through a start/ready/valid handshake.
- Sits in the execute stage; the stall logic holds the pipeline while ready=0.

Parameters:
- WIDTH, 16, datapath width. Multiple of 8, minimum 8.
- CNTW, $clog2(WIDTH), shift-count and iteration-counter width. Derived; not to be overridden.

Ports:
- clk     in   1        clock, rising edge.
- rst     in   1        reset, asynchronous, active-high.
- start   in   1        launch op. Sampled only when ready=1.
- op      in   4        opcode.
- A       in   WIDTH    operand A.
- B       in   WIDTH    operand B.
- Cin     in   1        adder carry-in.
- invA    in   1        invert A before use. Ignored for MUL/DIV.
- ready   out  1        unit idle; may accept start.
- valid   out  1        one-cycle pulse: result outputs updated this cycle.
- Out     out  WIDTH    primary result. MUL low half; DIV quotient.
- OutHi   out  WIDTH    MUL high half; DIV remainder; 0 for other ops.
- Ofl     out  1        overflow flag.
- Z       out  1        Out==0.
- N       out  1        Out[WIDTH-1].
- Cout    out  1        adder carry-out.
- err     out  1        illegal opcode, or divide by zero.

Behaviour:
- Reset (async, rst=1): state=IDLE; ready=1; valid=0; Out, OutHi, Ofl, Z, N, Cout, err = 0. Reset mid-operation aborts the operation with no valid pulse.
- Opcodes:
  - 0000 rll, 0001 sll, 0010 rrl, 0011 srl. Shift count = B[CNTW-1:0].
  - 0100 ADD = InA+B+Cin.
  - 0101 OR; 0110 XOR; 0111 ANDN = InA & ~B.
  - 1000 bit-reverse of InA.
  - 1001 SLBI = (InA << WIDTH/2) | zero-extended B[WIDTH/2-1:0].
  - 1011 LBI = B.
  - 1100 MUL, unsigned.
  - 1101 DIV, unsigned.
  - 1010, 1110, 1111: illegal.
- FSM states: IDLE, MUL, DIV.
  - IDLE & start & single-cycle op: results registered at that edge; valid=1 the next cycle; state stays IDLE; ready stays 1. Back-to-back single-cycle ops sustain 1 result per cycle.
  - IDLE & start & MUL: latch operands; ready=0; shift-add, one bit per cycle, for WIDTH cycles. Result written at the final edge; valid pulses in the cycle after it. Latency WIDTH+1 cycles start-to-valid. Returns to IDLE with ready=1 in the valid cycle.
  - DIV: restoring, one quotient bit per cycle. Same timing as MUL.
  - DIV with B==0: takes no iterations; 1-cycle latency. Out=all ones, OutHi=A, err=1.
- start while ready=0 is ignored; no queueing.
- Illegal op: 1-cycle latency; Out=0, OutHi=0, err=1; Z=1, N=0 (derived from Out as usual).
- Flags are updated only on a valid result and hold their value otherwise.
  - ADD: Ofl = (InA[MSB]==B[MSB]) & (Sum[MSB]!=InA[MSB]); Cout = carry out of MSB.
  - MUL: Ofl = (OutHi != 0); Cout=0.
  - All other ops: Ofl=0, Cout=0.
  - Z and N always derived from Out.
- Wrap-around: ADD truncates to WIDTH bits. Rotates take the count modulo WIDTH.
- Outputs hold until the next valid.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- When defined: DIV op and the divider datapath are present as described.
- When undefined: opcode 1101 is treated as illegal (1-cycle, err=1, Out=0, OutHi=0); no DIV state or divider logic is synthesised.

Decomposition:
- Package alu_mc_pkg holds:
  - opcode localparams (OP_RLL … OP_DIV);
  - FSM state enum (IDLE, MUL, DIV).
- One sub-module, muldiv_iter: the iterative shift-add / restoring-divide engine with its counter.
  - Ports: clk, rst, go, is_div, a, b → busy, done, lo, hi.
- The combinational ops stay in the top module; rotate/shift logic is a barrel shifter parametrised by WIDTH.

Test Plan (WIDTH=16):
- ADD: A=7FFF, B=0001, Cin=0 → one cycle later valid=1, Out=8000, Ofl=1, N=1, Cout=0, Z=0.
- MUL: A=00FF, B=0101 → ready=0 for 16 cycles; valid at cycle 17; Out=FFFF, OutHi=0000, Ofl=0. Then A=FFFF, B=FFFF → Out=0001, OutHi=FFFE, Ofl=1.
- DIV: A=0064, B=0007 → valid at cycle 17, Out=000E, OutHi=0002, err=0. Then B=0 → valid after 1 cycle, Out=FFFF, OutHi=0064, err=1.
- Handshake and reset: start MUL, pulse start with op=ADD at cycle 5 → ignored; only MUL result returned. Assert rst at cycle 8 of a MUL → all outputs 0, ready=1, no valid pulse.
- Single-cycle ops back to back:
  - rll A=8001 B=0001 → 0003.
  - SLBI A=0012 B=0034 → 1234.
  - bit-reverse A=0001 → 8000.
  - illegal op 1110 → err=1, Z=1.
  - One valid per cycle, four cycles in a row.
